sp_ram_banked: RTL

- Parametrised successor to the fixed 4x4 byte-macro data/instruction RAM.
- Single-port, byte-maskable RAM built from NUM_BANKS rows of byte-wide SRAM macros.
- Bank and word decode are derived from the parameters.
- Adds a registered read-bank select (read mux is correct after the address changes), a read-valid/hold path, and an optional post-reset zero-clear engine gated by a grant.
- Sits between the core/AXI memory adapter and the SRAM macros.

---
 rtl/sp_ram_banked_pkg.sv | 26 ++
 rtl/sp_ram_banked_if.sv | 27 ++
 rtl/sp_ram_banked_macro.sv | 43 ++++
 rtl/sp_ram_banked.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sp_ram_banked_pkg.sv
// Shared types and derived-width helpers for the banked byte-maskable RAM.
package sp_ram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  function automatic int off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int word_bits(input int bank_words);
    return $clog2(bank_words);
  endfunction

  // A single bank needs no select bits at all.
  function automatic int bank_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sp_ram_banked_if.sv
// Request/response bus between the memory adapter (master) and the banked RAM (slave).
interface sp_ram_banked_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);

  logic                    en_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic                    gnt_o;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    init_done_o;

  modport master (
    output en_i, addr_i, wdata_i, we_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, init_done_o
  );

  modport slave (
    input  en_i, addr_i, wdata_i, we_i, be_i,
    output gnt_o, rvalid_o, rdata_o, init_done_o
  );

endinterface

// File: rtl/sp_ram_banked_macro.sv
// Byte-wide single-port SRAM cell: active-low CSN/WEN, 1-cycle read latency, Q held between accesses.
module sram_byte_macro #(
  parameter int WORDS          = 2048,
  parameter int ABITS          = 11,
  parameter bit USE_TECH_MACRO = 1'b0
) (
  input  logic             CK,
  input  logic             CSN,
  input  logic             WEN,
  input  logic [ABITS-1:0] A,
  input  logic [7:0]       D,
  output logic [7:0]       Q
);

  if (USE_TECH_MACRO) begin : g_tech
`ifdef SP_RAM_ST_MACRO
    ST_SPHDL_2048x8m8_L u_macro (
      .CK  (CK),
      .CSN (CSN),
      .WEN (WEN),
      .A   (A),
      .D   (D),
      .Q   (Q)
    );
`else
    $error("sram_byte_macro: technology macro requested but SP_RAM_ST_MACRO is not defined");
`endif
  end else begin : g_model
    logic [7:0] mem [WORDS];

    // A write leaves Q untouched; only a read refreshes it.
    always_ff @(posedge CK) begin
      if (!CSN) begin
        if (!WEN) begin
          mem[A] <= D;
        end else begin
          Q <= mem[A];
        end
      end
    end
  end

endmodule

// File: rtl/sp_ram_banked.sv
// Banked, byte-maskable single-port RAM with registered read-bank select, read hold and post-reset clear.
module sp_ram_banked
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BANKS      = 4,
  parameter int BANK_WORDS     = 2048,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic           clk,
  input logic           rst,
  sp_ram_banked_if.slave bus
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int OFF_BITS  = off_bits(DATA_WIDTH);
  localparam int WORD_BITS = word_bits(BANK_WORDS);
  localparam int BANK_BITS = bank_bits(NUM_BANKS);
  localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

  if (ADDR_WIDTH < OFF_BITS + WORD_BITS + BANK_BITS) begin : g_chk_addr
    $error("sp_ram_banked: ADDR_WIDTH too small for the bank/word/offset fields");
  end
  if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_chk_data
    $error("sp_ram_banked: DATA_WIDTH must be a positive multiple of 8");
  end
  if (!is_pow2(NUM_BANKS)) begin : g_chk_banks
    $error("sp_ram_banked: NUM_BANKS must be a power of 2");
  end
  if (!is_pow2(BANK_WORDS) || (BANK_WORDS < 2)) begin : g_chk_words
    $error("sp_ram_banked: BANK_WORDS must be a power of 2 of at least 2");
  end

  state_e                 state;
  logic [WORD_BITS-1:0]   cnt;
  logic [WORD_BITS-1:0]   word;
  logic [BSEL_W-1:0]      bank;
  logic [BSEL_W-1:0]      rd_bank_q;
  logic                   gnt;
  logic                   clearing;
  logic                   rvalid;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   unused_addr;
  wire  [DATA_WIDTH-1:0]  q [NUM_BANKS];

  // Offset bits and anything above the bank field are don't-care, so addresses alias.
  assign unused_addr = ^bus.addr_i;
  assign word        = bus.addr_i[OFF_BITS +: WORD_BITS];

  if (BANK_BITS > 0) begin : g_bank_dec
    assign bank = bus.addr_i[OFF_BITS + WORD_BITS +: BANK_BITS];
  end else begin : g_single_bank
    assign bank = '0;
  end

  assign gnt      = bus.en_i & (state == READY) & ~rst;
  assign clearing = (state == CLEAR) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == WORD_BITS'(BANK_WORDS - 1)) begin
        state <= READY;
      end
    end
  end

  // The bank select is registered so the output mux tracks the read, not the live address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid    <= 1'b0;
      rd_bank_q <= '0;
      hold_q    <= '0;
    end else begin
      rvalid <= gnt & ~bus.we_i;
      if (gnt && !bus.we_i) begin
        rd_bank_q <= bank;
      end
      if (rvalid) begin
        hold_q <= rdata;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_bank_q == BSEL_W'(b)) begin
        rd_word = q[b];
      end
    end
  end

  assign rdata            = rvalid ? rd_word : hold_q;
  assign bus.rdata_o      = rdata;
  assign bus.rvalid_o     = rvalid;
  assign bus.gnt_o        = gnt;
  assign bus.init_done_o  = (state == READY);

  // The clear engine drives every macro at once; otherwise only the decoded bank is selected.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic                 csn;
      logic                 wen;
      logic [WORD_BITS-1:0] a;
      logic [7:0]           d;

      assign csn = ~(clearing | (gnt & (bank == BSEL_W'(b))));
      assign wen = clearing ? 1'b0 : ~(bus.we_i & bus.be_i[l]);
      assign a   = clearing ? cnt : word;
      assign d   = clearing ? 8'h00 : bus.wdata_i[8*l +: 8];

      sram_byte_macro #(
        .WORDS (BANK_WORDS),
        .ABITS (WORD_BITS)
      ) u_macro (
        .CK  (clk),
        .CSN (csn),
        .WEN (wen),
        .A   (a),
        .D   (d),
        .Q   (q[b][8*l +: 8])
      );
    end
  end

endmodule
